// File: rtl/dcache_pkg.sv
// Shared types and address helpers for the data-cache responder.
package dcache_pkg;

    localparam int ADDR_W  = 16;
    localparam int WORD_W  = 16;
    localparam int OFF_W   = 2;
    localparam int LINE_W  = 64;
    localparam int LADDR_W = ADDR_W - OFF_W;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WRBACK = 2'd1,
        FILL   = 2'd2
    } dc_state_t;

    function automatic logic [LADDR_W-1:0] line_addr(input logic [ADDR_W-1:0] addr);
        return addr[ADDR_W-1:OFF_W];
    endfunction

    function automatic logic [OFF_W-1:0] word_off(input logic [ADDR_W-1:0] addr);
        return addr[OFF_W-1:0];
    endfunction

    function automatic logic [WORD_W-1:0] word_sel(input logic [LINE_W-1:0] line,
                                                   input logic [OFF_W-1:0]  off);
        return line[off*WORD_W +: WORD_W];
    endfunction

endpackage

// File: rtl/dcache_array.sv
// Tag/valid/dirty/data storage for the direct-mapped data cache.
// Reads are asynchronous by index; word writes set dirty, line installs clear it.
module dcache_array
    import dcache_pkg::*;
#(
    parameter int INDEX_W = 5,
    parameter int TAG_W   = 9
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [INDEX_W-1:0] idx,
    output logic [TAG_W-1:0]   rd_tag,
    output logic               rd_valid,
    output logic               rd_dirty,
    output logic [LINE_W-1:0]  rd_line,
    input  logic               word_we,
    input  logic [OFF_W-1:0]   word_off_sel,
    input  logic [WORD_W-1:0]  word_data,
    input  logic               fill_we,
    input  logic [TAG_W-1:0]   fill_tag,
    input  logic [LINE_W-1:0]  fill_line
);

    localparam int LINES = 1 << INDEX_W;

    logic [TAG_W-1:0]  tag_mem  [LINES];
    logic [LINE_W-1:0] data_mem [LINES];
    logic [LINES-1:0]  line_valid;
    logic [LINES-1:0]  line_dirty;

    // Only the status bits are reset; tag/data contents are don't-care until valid.
    genvar gi;
    generate
        for (gi = 0; gi < LINES; gi++) begin : g_line
            localparam logic [INDEX_W-1:0] LINE_IDX = gi;
            logic valid_reg;
            logic dirty_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    valid_reg <= 1'b0;
                    dirty_reg <= 1'b0;
                end else if (idx == LINE_IDX) begin
                    if (fill_we) begin
                        valid_reg <= 1'b1;
                        dirty_reg <= 1'b0;
                    end else if (word_we) begin
                        dirty_reg <= 1'b1;
                    end
                end
            end

            assign line_valid[gi] = valid_reg;
            assign line_dirty[gi] = dirty_reg;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (fill_we) begin
            tag_mem[idx]  <= fill_tag;
            data_mem[idx] <= fill_line;
        end else if (word_we) begin
            data_mem[idx][word_off_sel*WORD_W +: WORD_W] <= word_data;
        end
    end

    assign rd_tag   = tag_mem[idx];
    assign rd_line  = data_mem[idx];
    assign rd_valid = line_valid[idx];
    assign rd_dirty = line_dirty[idx];

endmodule

// File: rtl/dcache_responder.sv
// Direct-mapped write-back/write-allocate data cache facing the CPU data port.
// Optional hit/miss counters are enabled with DCACHE_STATS_EN.
module dcache_responder
    import dcache_pkg::*;
#(
    parameter int INDEX_W = 5,
    parameter int TAG_W   = 9
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic                re,
    input  logic                we,
    input  logic [WORD_W-1:0]   wrt_data,
    output logic [WORD_W-1:0]   rd_data,
    output logic                d_rdy,
    output logic [LADDR_W-1:0]  mem_addr,
    output logic                mem_re,
    output logic                mem_we,
    output logic [LINE_W-1:0]   mem_wdata,
    input  logic [LINE_W-1:0]   mem_rdata,
    input  logic                mem_rdy
`ifdef DCACHE_STATS_EN
    ,
    output logic [15:0]         hit_cnt,
    output logic [15:0]         miss_cnt
`endif
);

    dc_state_t           state_reg;
    logic                mem_re_reg;
    logic                mem_we_reg;
    logic [LADDR_W-1:0]  mem_addr_reg;
    logic [LINE_W-1:0]   mem_wdata_reg;

    logic [INDEX_W-1:0]  idx;
    logic [TAG_W-1:0]    tag;
    logic [OFF_W-1:0]    off;
    logic [TAG_W-1:0]    line_tag;
    logic                line_valid;
    logic                line_dirty;
    logic [LINE_W-1:0]   line_data;
    logic                req;
    logic                hit;
    logic                miss;
    logic                in_idle;
    logic                word_we;
    logic                fill_we;

    assign idx     = d_addr[INDEX_W+OFF_W-1:OFF_W];
    assign tag     = d_addr[ADDR_W-1:INDEX_W+OFF_W];
    assign off     = word_off(d_addr);
    assign req     = re | we;
    assign hit     = line_valid && (line_tag == tag);
    assign miss    = req && !hit;
    assign in_idle = (state_reg == IDLE);
    assign word_we = in_idle && we && hit;
    assign fill_we = (state_reg == FILL) && mem_rdy;

    dcache_array #(
        .INDEX_W (INDEX_W),
        .TAG_W   (TAG_W)
    ) u_array (
        .clk          (clk),
        .rst_n        (rst_n),
        .idx          (idx),
        .rd_tag       (line_tag),
        .rd_valid     (line_valid),
        .rd_dirty     (line_dirty),
        .rd_line      (line_data),
        .word_we      (word_we),
        .word_off_sel (off),
        .word_data    (wrt_data),
        .fill_we      (fill_we),
        .fill_tag     (tag),
        .fill_line    (mem_rdata)
    );

    // A miss drops d_rdy in the same cycle; while reset is held the port reports ready.
    assign d_rdy   = !rst_n || (in_idle && !miss);
    assign rd_data = (in_idle && re && !we && hit) ? word_sel(line_data, off) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            mem_re_reg    <= 1'b0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (miss) begin
                        if (line_valid && line_dirty) begin
                            state_reg     <= WRBACK;
                            mem_we_reg    <= 1'b1;
                            mem_addr_reg  <= {line_tag, idx};
                            mem_wdata_reg <= line_data;
                        end else begin
                            state_reg    <= FILL;
                            mem_re_reg   <= 1'b1;
                            mem_addr_reg <= line_addr(d_addr);
                        end
                    end
                end
                WRBACK: begin
                    if (mem_rdy) begin
                        state_reg    <= FILL;
                        mem_we_reg   <= 1'b0;
                        mem_re_reg   <= 1'b1;
                        mem_addr_reg <= line_addr(d_addr);
                    end
                end
                FILL: begin
                    if (mem_rdy) begin
                        state_reg  <= IDLE;
                        mem_re_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg  <= IDLE;
                    mem_re_reg <= 1'b0;
                    mem_we_reg <= 1'b0;
                end
            endcase
        end
    end

    assign mem_re    = mem_re_reg;
    assign mem_we    = mem_we_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;

`ifdef DCACHE_STATS_EN
    logic [15:0] hit_cnt_reg;
    logic [15:0] miss_cnt_reg;
    logic        fill_done_reg;

    // The replayed access right after a fill is the tail of a miss, not a new hit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt_reg   <= '0;
            miss_cnt_reg  <= '0;
            fill_done_reg <= 1'b0;
        end else begin
            fill_done_reg <= fill_we;
            if (in_idle && req && hit && !fill_done_reg && hit_cnt_reg != 16'hFFFF)
                hit_cnt_reg <= hit_cnt_reg + 16'd1;
            if (in_idle && miss && miss_cnt_reg != 16'hFFFF)
                miss_cnt_reg <= miss_cnt_reg + 16'd1;
        end
    end

    assign hit_cnt  = hit_cnt_reg;
    assign miss_cnt = miss_cnt_reg;
`endif

endmodule

// File: tb/tb_dcache_responder.sv
// Directed self-checking bench for dcache_responder with a fixed-latency line memory model.
module tb_dcache_responder;

    localparam int LMEM = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] d_addr = '0;
    logic        re = 1'b0;
    logic        we = 1'b0;
    logic [15:0] wrt_data = '0;
    logic [15:0] rd_data;
    logic        d_rdy;
    logic [13:0] mem_addr;
    logic        mem_re;
    logic        mem_we;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata = '0;
    logic        mem_rdy = 1'b0;
`ifdef DCACHE_STATS_EN
    logic [15:0] hit_cnt;
    logic [15:0] miss_cnt;
`endif

    dcache_responder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .d_addr    (d_addr),
        .re        (re),
        .we        (we),
        .wrt_data  (wrt_data),
        .rd_data   (rd_data),
        .d_rdy     (d_rdy),
        .mem_addr  (mem_addr),
        .mem_re    (mem_re),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_rdy   (mem_rdy)
`ifdef DCACHE_STATS_EN
        ,
        .hit_cnt   (hit_cnt),
        .miss_cnt  (miss_cnt)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Backing memory: mem_rdy pulses in the LMEM-th cycle of each request.
    logic [63:0] mem_store [logic [13:0]];
    logic        txn_we   [$];
    logic [13:0] txn_addr [$];
    logic [63:0] txn_data [$];
    int          mcnt = 0;
    logic        both_seen = 1'b0;

    function automatic logic [63:0] mem_line(input logic [13:0] a);
        logic [63:0] l;
        if (mem_store.exists(a)) return mem_store[a];
        for (int w = 0; w < 4; w++) begin
            logic [1:0] wi;
            wi = 2'(w);
            l[w*16 +: 16] = {wi, a};
        end
        return l;
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            mcnt    = 0;
            mem_rdy = 1'b0;
        end else begin
            if (mem_re && mem_we) both_seen = 1'b1;
            if (mem_rdy) mcnt = 0;
            if (mem_re || mem_we) mcnt++;
            else mcnt = 0;
            mem_rdy = (mcnt == LMEM);
            if (mem_re) mem_rdata = mem_line(mem_addr);
            if (mem_rdy) begin
                txn_we.push_back(mem_we);
                txn_addr.push_back(mem_addr);
                txn_data.push_back(mem_wdata);
                if (mem_we) mem_store[mem_addr] = mem_wdata;
            end
        end
    end

    // Starts just after a posedge; returns just after the completing posedge.
    task automatic do_access(input logic [15:0] a, input logic r, input logic w,
                             input logic [15:0] wd, output int stalls, output logic [15:0] rd);
        d_addr = a; re = r; we = w; wrt_data = wd;
        stalls = 0;
        @(negedge clk);
        while (!d_rdy && stalls < 50) begin
            stalls++;
            @(negedge clk);
        end
        rd = rd_data;
        $display("access addr=%04h re=%0b we=%0b wdata=%04h stalls=%0d rd_data=%04h",
                 a, r, w, wd, stalls, rd);
        @(posedge clk);
        #1;
        re = 1'b0; we = 1'b0;
    endtask

    int          st;
    logic [15:0] rd;
    logic [63:0] init_line;

    initial begin
        init_line = {16'h3333, 16'h2222, 16'hBEEF, 16'h0000};
        mem_store[14'h0021] = init_line;

        // Reset state
        @(negedge clk);
        check("rst_d_rdy", d_rdy, 1);
        check("rst_mem_re", mem_re, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_rd_data", rd_data, 0);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Cold read
        do_access(16'h0085, 1, 0, 16'h0, st, rd);
        check("cold_stalls", st, 4);
        check("cold_rd", rd, 16'hBEEF);
        check("cold_txn_cnt", txn_we.size(), 1);
        check("cold_txn_is_read", txn_we[0], 0);
        check("cold_txn_addr", txn_addr[0], 14'h0021);

        // Write hit, no memory traffic
        do_access(16'h0086, 0, 1, 16'h1234, st, rd);
        check("wr_stalls", st, 0);
        check("wr_rd_zero", rd, 0);
        check("wr_txn_cnt", txn_we.size(), 1);

        do_access(16'h0086, 1, 0, 16'h0, st, rd);
        check("rdback_stalls", st, 0);
        check("rdback_rd", rd, 16'h1234);

        // Dirty eviction by same index, new tag
        do_access(16'h0106, 1, 0, 16'h0, st, rd);
        check("evict_stalls", st, 7);
        check("evict_txn_cnt", txn_we.size(), 3);
        check("evict_wb_is_write", txn_we[1], 1);
        check("evict_wb_addr", txn_addr[1], 14'h0021);
        check("evict_wb_word2", txn_data[1][47:32], 16'h1234);
        check("evict_fill_is_read", txn_we[2], 0);
        check("evict_fill_addr", txn_addr[2], 14'h0041);
        check("evict_rd", rd, 16'h8041);
`ifdef DCACHE_STATS_EN
        check("stats_hit", hit_cnt, 2);
        check("stats_miss", miss_cnt, 2);
`endif

        // re and we together act as a write
        do_access(16'h0106, 1, 1, 16'h5555, st, rd);
        check("rw_stalls", st, 0);
        check("rw_rd_zero", rd, 0);
        do_access(16'h0106, 1, 0, 16'h0, st, rd);
        check("rw_rdback", rd, 16'h5555);

        // Reset in the middle of a fill
        d_addr = 16'h0200; re = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("midrst_mem_re_before", mem_re, 1);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_mem_re", mem_re, 0);
        check("midrst_d_rdy", d_rdy, 1);
        check("midrst_rd_data", rd_data, 0);
        re = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        do_access(16'h0200, 1, 0, 16'h0, st, rd);
        check("post_rst_stalls", st, 4);
        check("post_rst_rd", rd, 16'h0080);
        do_access(16'h0085, 1, 0, 16'h0, st, rd);
        check("post_rst_old_line_miss", st, 4);
        check("post_rst_old_rd", rd, 16'hBEEF);
`ifdef DCACHE_STATS_EN
        check("post_rst_miss_cnt", miss_cnt, 2);
        // Hold a hitting read long enough to saturate the hit counter
        d_addr = 16'h0200; re = 1'b1;
        for (int i = 0; i < 65540; i++) @(posedge clk);
        #1 re = 1'b0;
        check("stats_hit_sat", hit_cnt, 16'hFFFF);
`endif

        check("mem_re_we_exclusive", both_seen, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
